// File: rtl/eq_pkg.sv
// Shared widths, state encoding and fixed-point helpers for the band mixer
// equalizer stage.
package eq_pkg;

  localparam int NUM_BANDS  = 5;
  localparam int SMPL_W     = 16;
  localparam int GAIN_W     = 12;
  localparam int ACC_W      = 32;
  localparam int GAIN_SHIFT = 11;
  localparam int VOL_SHIFT  = 12;
  localparam int PROD_W     = SMPL_W + GAIN_W + 1;
  localparam int IDX_W      = 3;

  typedef enum logic [2:0] {IDLE, MAC_L, VOL_L, MAC_R, VOL_R, DONE} state_t;

  typedef logic signed [SMPL_W-1:0] smpl_t;
  typedef logic [GAIN_W-1:0]        gain_t;

  function automatic smpl_t sat16(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] s;
    s = acc >>> GAIN_SHIFT;
    if (s > 32'sd32767)
      return 16'sh7FFF;
    else if (s < -32'sd32768)
      return 16'sh8000;
    else
      return smpl_t'(s);
  endfunction

  function automatic logic sat_hit(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] s;
    s = acc >>> GAIN_SHIFT;
    return (s > 32'sd32767) || (s < -32'sd32768);
  endfunction

  // |s * 4095| >> 12 always fits 16 bits, so truncation here never wraps.
  function automatic smpl_t vol_apply(input smpl_t s, input gain_t vol);
    logic signed [PROD_W-1:0] p;
    p = PROD_W'(s) * PROD_W'($signed({1'b0, vol}));
    return smpl_t'(p >>> VOL_SHIFT);
  endfunction

endpackage

// File: rtl/band_mixer_if.sv
// Band-set / result bus between the equalizer front end, band_mixer and the
// speaker driver. clip_cnt only exists when CLIP_CNT_EN is defined.
interface band_mixer_if;
  import eq_pkg::*;

  logic                          vld_in;
  logic [NUM_BANDS*SMPL_W-1:0]   lft_bnd;
  logic [NUM_BANDS*SMPL_W-1:0]   rght_bnd;
  logic [NUM_BANDS*GAIN_W-1:0]   gain;
  gain_t                         volume;
  smpl_t                         lft_chnnl;
  smpl_t                         rght_chnnl;
  logic                          vld;
  logic                          busy;
`ifdef CLIP_CNT_EN
  logic [7:0]                    clip_cnt;
`endif

  modport master (
    output vld_in, lft_bnd, rght_bnd, gain, volume,
    input  lft_chnnl, rght_chnnl, vld, busy
`ifdef CLIP_CNT_EN
    , input clip_cnt
`endif
  );

  modport slave (
    input  vld_in, lft_bnd, rght_bnd, gain, volume,
    output lft_chnnl, rght_chnnl, vld, busy
`ifdef CLIP_CNT_EN
    , output clip_cnt
`endif
  );

endinterface

// File: rtl/sat_mac.sv
// Time-shared signed multiply-accumulate with clear/enable; presents the
// accumulator scaled by >>>11 and saturated to 16 bits, plus a saturation flag.
module sat_mac
  import eq_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clr,
  input  logic  en,
  input  smpl_t sample,
  input  gain_t coef,
  output smpl_t acc_sat,
  output logic  sat
);

  logic signed [ACC_W-1:0]  acc;
  logic signed [PROD_W-1:0] prod;

  // Gains are unsigned, so a zero sign bit keeps them positive in the product.
  assign prod = PROD_W'(sample) * PROD_W'($signed({1'b0, coef}));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      acc <= '0;
    else if (clr)
      acc <= '0;
    else if (en)
      acc <= acc + ACC_W'(prod);
  end

  assign acc_sat = sat16(acc);
  assign sat     = sat_hit(acc);

endmodule

// File: rtl/band_mixer.sv
// Equalizer mixing stage: gain-weighted band sum per channel, then volume.
// Define CLIP_CNT_EN to add the saturating clip_cnt event counter.
module band_mixer
  import eq_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  band_mixer_if.slave  bus
);

  state_t             state, nxt_state;
  logic [IDX_W-1:0]   idx;
  smpl_t              lft_q  [NUM_BANDS];
  smpl_t              rght_q [NUM_BANDS];
  gain_t              gain_q [NUM_BANDS];
  gain_t              vol_q;
  smpl_t              lft_res;
  logic               mac_clr, mac_en, mac_sat;
  smpl_t              mac_sample, acc_sat;
  gain_t              mac_coef;
  logic               last_band;

  assign last_band = (idx == IDX_W'(NUM_BANDS - 1));

  sat_mac u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (mac_clr),
    .en      (mac_en),
    .sample  (mac_sample),
    .coef    (mac_coef),
    .acc_sat (acc_sat),
    .sat     (mac_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    unique case (state)
      IDLE:    if (bus.vld_in) nxt_state = MAC_L;
      MAC_L:   if (last_band)  nxt_state = VOL_L;
      VOL_L:   nxt_state = MAC_R;
      MAC_R:   if (last_band)  nxt_state = VOL_R;
      VOL_R:   nxt_state = DONE;
      DONE:    nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  // The accumulator is cleared on capture and again as each VOL stage consumes it.
  always_comb begin
    mac_clr    = 1'b0;
    mac_en     = 1'b0;
    mac_sample = lft_q[idx];
    mac_coef   = gain_q[idx];
    bus.busy   = (state != IDLE);
    bus.vld    = (state == DONE);
    unique case (state)
      IDLE:    mac_clr = bus.vld_in;
      MAC_L:   mac_en  = 1'b1;
      VOL_L:   mac_clr = 1'b1;
      MAC_R: begin
        mac_en     = 1'b1;
        mac_sample = rght_q[idx];
      end
      VOL_R:   mac_clr = 1'b1;
      default: mac_clr = 1'b0;
    endcase
  end

  // Both output ports load together on the VOL_R edge so the pair never tears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_BANDS; k++) begin
        lft_q[k]  <= '0;
        rght_q[k] <= '0;
        gain_q[k] <= '0;
      end
      vol_q          <= '0;
      idx            <= '0;
      lft_res        <= '0;
      bus.lft_chnnl  <= '0;
      bus.rght_chnnl <= '0;
    end else begin
      unique case (state)
        IDLE: if (bus.vld_in) begin
          for (int k = 0; k < NUM_BANDS; k++) begin
            lft_q[k]  <= bus.lft_bnd[k*SMPL_W +: SMPL_W];
            rght_q[k] <= bus.rght_bnd[k*SMPL_W +: SMPL_W];
            gain_q[k] <= bus.gain[k*GAIN_W +: GAIN_W];
          end
          vol_q <= bus.volume;
          idx   <= '0;
        end
        MAC_L, MAC_R: idx <= idx + IDX_W'(1);
        VOL_L: begin
          lft_res <= vol_apply(acc_sat, vol_q);
          idx     <= '0;
        end
        VOL_R: begin
          bus.lft_chnnl  <= lft_res;
          bus.rght_chnnl <= vol_apply(acc_sat, vol_q);
          idx            <= '0;
        end
        default: idx <= '0;
      endcase
    end
  end

`ifdef CLIP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bus.clip_cnt <= '0;
    else if ((state == VOL_L || state == VOL_R) && mac_sat && bus.clip_cnt != 8'hFF)
      bus.clip_cnt <= bus.clip_cnt + 8'd1;
  end
`else
  logic sat_unused;
  assign sat_unused = mac_sat;
`endif

endmodule

// File: tb/tb_band_mixer.sv
// Directed-vector bench for band_mixer: table of band sets with hand-computed
// results, plus busy-ignore and mid-operation reset sequences.
module tb_band_mixer;
  import eq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  band_mixer_if bus();

  band_mixer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string                       name;
    logic [NUM_BANDS*SMPL_W-1:0] lft;
    logic [NUM_BANDS*SMPL_W-1:0] rght;
    logic [NUM_BANDS*GAIN_W-1:0] gain;
    logic [GAIN_W-1:0]           vol;
    int                          exp_l;
    int                          exp_r;
    int                          clip_inc;
  } vec_t;

  vec_t vecs[6];
  int   vec_count  = 0;
  int   miscompares = 0;
  int   exp_clip   = 0;
  int   lat, pulses;
  logic b1, b13;

  task automatic checkOutput(input string name, input int act, input int exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drives one band set (sampled at E0), then runs 26 cycles recording the
  // first vld latency, vld pulse count and busy after E1/E13. Optionally
  // injects a second set sampled at edge inj_at, or pulses rst_n low at rst_at.
  task automatic applyStimulus(input vec_t v, input int inj_at, input vec_t vb,
                               input int rst_at, output int lat_o,
                               output int pulses_o, output logic b1_o,
                               output logic b13_o);
    @(negedge clk);
    bus.lft_bnd  = v.lft;
    bus.rght_bnd = v.rght;
    bus.gain     = v.gain;
    bus.volume   = v.vol;
    bus.vld_in   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.vld_in = 1'b0;
    lat_o = -1;
    pulses_o = 0;
    b1_o = 1'b0;
    b13_o = 1'b1;
    for (int n = 1; n <= 26; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.vld === 1'b1) begin
        pulses_o++;
        if (lat_o < 0) lat_o = n;
      end
      if (n == 1)  b1_o  = bus.busy;
      if (n == 13) b13_o = bus.busy;
      if (n == inj_at - 1) begin
        bus.lft_bnd  = vb.lft;
        bus.rght_bnd = vb.rght;
        bus.gain     = vb.gain;
        bus.volume   = vb.vol;
        bus.vld_in   = 1'b1;
      end
      if (n == inj_at)     bus.vld_in = 1'b0;
      if (n == rst_at - 1) rst_n = 1'b0;
      if (n == rst_at)     rst_n = 1'b1;
    end
  endtask

  initial begin
    bus.vld_in   = 1'b0;
    bus.lft_bnd  = '0;
    bus.rght_bnd = '0;
    bus.gain     = '0;
    bus.volume   = '0;

    vecs[0] = '{"unity", {16'h0, 16'h0, 16'h0, 16'h0, 16'd1000},
                {16'h0, 16'h0, 16'hFE70, 16'h0, 16'h0},
                {5{12'h800}}, 12'h800, 500, -200, 0};
    vecs[1] = '{"pos_sat", {5{16'h7FFF}}, {5{16'h0}},
                {5{12'hFFF}}, 12'hFFF, 32759, 0, 1};
    vecs[2] = '{"neg_sat", {5{16'h0}}, {5{16'h8000}},
                {5{12'hFFF}}, 12'hFFF, 0, -32760, 1};
    vecs[3] = '{"zero_gain", {5{16'h1234}}, {5{16'hC000}},
                {5{12'h000}}, 12'hFFF, 0, 0, 0};
    vecs[4] = '{"floor", {16'd500, 16'd400, 16'd300, 16'd200, 16'd100},
                {16'h0, 16'h0, 16'h0, 16'hFFFD, 16'h0},
                {12'h800, 12'h800, 12'h800, 12'h400, 12'h800}, 12'hFFF,
                1399, -2, 0};
    vecs[5] = '{"mixed", {16'h0, 16'hFC18, 16'h0, 16'h0, 16'h0},
                {16'd20000, 16'h0, 16'h0, 16'h0, 16'd20000},
                {12'h800, 12'hC00, 12'h000, 12'h000, 12'h800}, 12'h400,
                -375, 8191, 1};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset.lft", bus.lft_chnnl, 0);
    checkOutput("reset.rght", bus.rght_chnnl, 0);
    checkOutput("reset.vld", int'(bus.vld), 0);
    checkOutput("reset.busy", int'(bus.busy), 0);
`ifdef CLIP_CNT_EN
    checkOutput("reset.clip", int'(bus.clip_cnt), 0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i], 0, vecs[i], 0, lat, pulses, b1, b13);
      exp_clip += vecs[i].clip_inc;
      checkOutput({vecs[i].name, ".latency"}, lat, 12);
      checkOutput({vecs[i].name, ".pulses"}, pulses, 1);
      checkOutput({vecs[i].name, ".busy_e1"}, int'(b1), 1);
      checkOutput({vecs[i].name, ".busy_e13"}, int'(b13), 0);
      checkOutput({vecs[i].name, ".lft"}, bus.lft_chnnl, vecs[i].exp_l);
      checkOutput({vecs[i].name, ".rght"}, bus.rght_chnnl, vecs[i].exp_r);
`ifdef CLIP_CNT_EN
      checkOutput({vecs[i].name, ".clip"}, int'(bus.clip_cnt), exp_clip);
`endif
    end

    // Second set offered at E5 while busy must be dropped entirely.
    applyStimulus(vecs[0], 5, vecs[1], 0, lat, pulses, b1, b13);
    checkOutput("busy_ign.latency", lat, 12);
    checkOutput("busy_ign.pulses", pulses, 1);
    checkOutput("busy_ign.lft", bus.lft_chnnl, 500);
    checkOutput("busy_ign.rght", bus.rght_chnnl, -200);
`ifdef CLIP_CNT_EN
    checkOutput("busy_ign.clip", int'(bus.clip_cnt), exp_clip);
`endif

    // Reset at E8 aborts the set: no vld, outputs and counter cleared.
    applyStimulus(vecs[1], 0, vecs[1], 8, lat, pulses, b1, b13);
    exp_clip = 0;
    checkOutput("mid_rst.pulses", pulses, 0);
    checkOutput("mid_rst.busy", int'(bus.busy), 0);
    checkOutput("mid_rst.lft", bus.lft_chnnl, 0);
    checkOutput("mid_rst.rght", bus.rght_chnnl, 0);
`ifdef CLIP_CNT_EN
    checkOutput("mid_rst.clip", int'(bus.clip_cnt), exp_clip);
`endif

    applyStimulus(vecs[4], 0, vecs[4], 0, lat, pulses, b1, b13);
    checkOutput("post_rst.latency", lat, 12);
    checkOutput("post_rst.pulses", pulses, 1);
    checkOutput("post_rst.lft", bus.lft_chnnl, 1399);
    checkOutput("post_rst.rght", bus.rght_chnnl, -2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule

// File: doc/band_mixer.md
# band_mixer

Per-channel equalizer mixing stage that sits directly upstream of the speaker driver. It captures five filtered band samples per channel, five band gains and a master volume on a one-cycle `vld_in` pulse. It forms the gain-weighted, saturated band sum for left then right using a single time-shared multiplier, applies volume, and presents `lft_chnnl`/`rght_chnnl` with a one-cycle `vld` that the speaker driver latches.

## Interface
- NUM_BANDS, 5, bands per channel
- SMPL_W, 16, signed sample width
- GAIN_W, 12, unsigned gain/volume width
- Reset is `rst_n`, asynchronous, active-low. Clock is `clk`.
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- vld_in  input  1  one-cycle strobe: new band set present
- lft_bnd  input  NUM_BANDS*SMPL_W  signed left band samples, band k at [16k+15:16k]
- rght_bnd  input  NUM_BANDS*SMPL_W  signed right band samples, same packing
- gain  input  NUM_BANDS*GAIN_W  unsigned band gains, band k at [12k+11:12k], 12'h800 = unity
- volume  input  GAIN_W  unsigned master volume, 12'hFFF ≈ unity
- lft_chnnl  output  SMPL_W  signed left result, held between updates
- rght_chnnl  output  SMPL_W  signed right result, held between updates
- vld  output  1  one-cycle pulse when both channels are updated
- busy  output  1  high from the capture edge until the `vld` cycle inclusive
- clip_cnt  output  8  saturation event counter (only with CLIP_CNT_EN)

## Operation
- Reset: `lft_chnnl`=0, `rght_chnnl`=0, `vld`=0, `busy`=0, `clip_cnt`=0, state IDLE, accumulator and captured registers cleared.
- IDLE: `vld_in`=1 captures `lft_bnd`, `rght_bnd`, `gain` and `volume` into internal registers. The accumulator is cleared, the band index is set to 0, and the state goes to MAC_L.
- MAC_L: each cycle, acc += lft[idx] * $signed({1'b0,gain[idx]}). Product is 29 bits. acc is 32 bits signed. After idx=4, go to VOL_L.
- VOL_L:
  - s = acc >>> 11 (arithmetic, floor), saturated to [-32768, 32767].
  - Left result = (s * $signed({1'b0,volume})) >>> 12, stored to an internal register.
  - Clear acc and idx, then go to MAC_R.
- MAC_R and VOL_R: identical to the left path, operating on the right samples.
- After VOL_R, both `lft_chnnl` and `rght_chnnl` update on the same edge, `vld` pulses, and the state goes to DONE.
- DONE: return to IDLE on the next edge.
- Neither output port changes except on the `vld` edge, so the downstream driver never sees a half-updated pair.
- `vld_in` while `busy`=1 is ignored. No queuing and no capture of new data.
- Volume stage never overflows because |s*4095>>12| < 2^15. No second saturation.
- Reset mid-operation aborts immediately: outputs return to 0 and no `vld` is issued.

## Timing
- Edge E0 samples `vld_in`=1 (capture).
- Edges E1..E5: left MACs.
- E6: VOL_L.
- E7..E11: right MACs.
- E12: VOL_R. Outputs and `vld`=1 become visible after E12.
- Latency is 12 cycles from the capture edge. Throughput is 1 set per 14 cycles.
- `busy` is registered: high after E0, low after E13.
- `vld_in` may be asserted again in the cycle `busy` falls (sampled at E14).

## Configuration
- CLIP_CNT_EN defined:
  - `clip_cnt` port exists.
  - It increments by 1 for each VOL_L/VOL_R cycle in which saturation occurs, so up to +2 per set.
  - It saturates at 8'hFF and is cleared only by reset.
- CLIP_CNT_EN undefined: the port and counter are absent. Mixing behaviour is otherwise identical.

## Structure
- Shared package `eq_pkg`:
  - NUM_BANDS, SMPL_W, GAIN_W, ACC_W=32, GAIN_SHIFT=11, VOL_SHIFT=12.
  - State enum {IDLE, MAC_L, VOL_L, MAC_R, VOL_R, DONE}.
  - A `sat16` function.
- Sub-module `sat_mac`: signed multiplier and accumulator with clear/enable, plus the saturating >>>11 output. Shared by both channel phases.

## Test plan
- Band gain and volume: left band0=1000 with other bands 0, gains all 12'h800, volume 12'h800, right band2=-400 → `lft_chnnl`=500, `rght_chnnl`=-200. `vld` pulses exactly 12 cycles after capture.
- Positive saturation: all left bands 16'h7FFF, gains 12'hFFF, volume 12'hFFF → `lft_chnnl`=32759. With CLIP_CNT_EN, `clip_cnt` increments.
- Negative saturation: all right bands 16'h8000, gains 12'hFFF, volume 12'hFFF → `rght_chnnl`=-32760.
- Busy handling: `vld_in` pulsed at E5 with different data → ignored. Outputs match the first set only and exactly one `vld` is produced.
- Reset mid-operation: `rst_n` pulsed low at E8 → outputs 0, `busy`=0, no `vld`. The next `vld_in` is processed normally.
- Zero gain: all gains 0 with nonzero bands → both outputs 0, `vld` pulses, `clip_cnt` unchanged.
